// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch/decode/execute/memory/writeback,
// driving ALU control, operand selects and memory/register strobes. PCWrite in BRANCH is the
// only output that looks at the ALU Zero flag.
module mips_multicycle_control #(
  parameter bit         ENABLE_BNE  = 1'b1,
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic [3:0] ALUctl,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       Illegal,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAdr  = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StExecR   = 4'd6,
    StAluWb   = 4'd7,
    StBranch  = 4'd8,
    StJump    = 4'd9,
    StImmEx   = 4'd10,
    StImmWb   = 4'd11,
    StIllegal = 4'd12
  } state_e;

  localparam logic [5:0] OpRType = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpSlti  = 6'h0A;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [3:0] AluAnd = 4'd0;
  localparam logic [3:0] AluOr  = 4'd1;
  localparam logic [3:0] AluAdd = 4'd2;
  localparam logic [3:0] AluSub = 4'd6;
  localparam logic [3:0] AluSlt = 4'd7;
  localparam logic [3:0] AluNor = 4'd12;

  state_e     state_q, state_d;
  logic [3:0] r_ctl;
  logic       r_legal;

  // State register, asynchronously forced to the reset state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= state_e'(RESET_STATE);
    end else begin
      state_q <= state_d;
    end
  end

  // R-type function decode; unknown functs add by default and are flagged illegal.
  always_comb begin
    r_ctl   = AluAdd;
    r_legal = 1'b1;
    case (Funct)
      6'h20:   r_ctl = AluAdd;
      6'h22:   r_ctl = AluSub;
      6'h24:   r_ctl = AluAnd;
      6'h25:   r_ctl = AluOr;
      6'h2A:   r_ctl = AluSlt;
      6'h27:   r_ctl = AluNor;
      default: r_legal = 1'b0;
    endcase
  end

  // Next-state and output decode of the current state; reset overrides all outputs.
  always_comb begin
    state_d  = StFetch;
    ALUctl   = 4'd0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'd0;
    PCSource = 2'd0;
    PCWrite  = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    Illegal  = 1'b0;

    case (state_q)
      StFetch: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
        ALUSrcB = 2'd1;
        ALUctl  = AluAdd;
        PCWrite = 1'b1;
        state_d = StDecode;
      end
      StDecode: begin
        // Speculatively compute the branch target while the opcode is decoded.
        ALUSrcB = 2'd3;
        ALUctl  = AluAdd;
        case (Op)
          OpLw, OpSw:     state_d = StMemAdr;
          OpRType:        state_d = StExecR;
          OpBeq:          state_d = StBranch;
          OpBne:          state_d = ENABLE_BNE ? StBranch : StIllegal;
          OpJ:            state_d = StJump;
          OpAddi, OpSlti: state_d = StImmEx;
          default:        state_d = StIllegal;
        endcase
      end
      StMemAdr: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'd2;
        ALUctl  = AluAdd;
        state_d = (Op == OpLw) ? StMemRd : StMemWr;
      end
      StMemRd: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        state_d = StMemWb;
      end
      StMemWb: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        state_d  = StFetch;
      end
      StMemWr: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        state_d  = StFetch;
      end
      StExecR: begin
        ALUSrcA = 1'b1;
        ALUctl  = r_ctl;
        state_d = r_legal ? StAluWb : StIllegal;
      end
      StAluWb: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        state_d  = StFetch;
      end
      StBranch: begin
        ALUSrcA  = 1'b1;
        ALUctl   = AluSub;
        PCSource = 2'd1;
        PCWrite  = (Op == OpBne) ? ~Zero : Zero;
        state_d  = StFetch;
      end
      StJump: begin
        PCSource = 2'd2;
        PCWrite  = 1'b1;
        state_d  = StFetch;
      end
      StImmEx: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'd2;
        ALUctl  = (Op == OpSlti) ? AluSlt : AluAdd;
        state_d = StImmWb;
      end
      StImmWb: begin
        RegWrite = 1'b1;
        state_d  = StFetch;
      end
      StIllegal: begin
        Illegal = 1'b1;
        state_d = StFetch;
      end
      default: state_d = StFetch;
    endcase

    if (reset) begin
      ALUctl   = AluAdd;
      ALUSrcA  = 1'b0;
      ALUSrcB  = 2'd0;
      PCSource = 2'd0;
      PCWrite  = 1'b0;
      IorD     = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      RegDst   = 1'b0;
      MemtoReg = 1'b0;
      RegWrite = 1'b0;
      Illegal  = 1'b0;
    end
  end

  assign State = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Self-checking bench: two control units (bne enabled / disabled) run in lockstep against a
// per-instruction reference that lists the expected control word for every cycle.
module tb_mips_multicycle_control;

  typedef struct packed {
    logic [3:0] st;
    logic [3:0] alu;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] pcsrc;
    logic       pcw;
    logic       iord;
    logic       mrd;
    logic       mwr;
    logic       irw;
    logic       rdst;
    logic       m2r;
    logic       rw;
    logic       ill;
  } cyc_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] Op    = 6'h00;
  logic [5:0] Funct = 6'h20;
  logic       Zero  = 1'b0;

  logic [3:0] alu_a, alu_b, st_a, st_b;
  logic       srca_a, srca_b;
  logic [1:0] srcb_a, srcb_b, pcs_a, pcs_b;
  logic       pcw_a, iord_a, mrd_a, mwr_a, irw_a, rdst_a, m2r_a, rw_a, ill_a;
  logic       pcw_b, iord_b, mrd_b, mwr_b, irw_b, rdst_b, m2r_b, rw_b, ill_b;

  cyc_t obs_a, obs_b;
  cyc_t exp_q[$];
  cyc_t exp_a[$];
  cyc_t exp_b[$];

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  mips_multicycle_control #(.ENABLE_BNE(1'b1), .RESET_STATE(4'd0)) dut_a (
    .clock(clock), .reset(reset), .Op(Op), .Funct(Funct), .Zero(Zero),
    .ALUctl(alu_a), .ALUSrcA(srca_a), .ALUSrcB(srcb_a), .PCSource(pcs_a), .PCWrite(pcw_a),
    .IorD(iord_a), .MemRead(mrd_a), .MemWrite(mwr_a), .IRWrite(irw_a), .RegDst(rdst_a),
    .MemtoReg(m2r_a), .RegWrite(rw_a), .Illegal(ill_a), .State(st_a)
  );

  mips_multicycle_control #(.ENABLE_BNE(1'b0), .RESET_STATE(4'd0)) dut_b (
    .clock(clock), .reset(reset), .Op(Op), .Funct(Funct), .Zero(Zero),
    .ALUctl(alu_b), .ALUSrcA(srca_b), .ALUSrcB(srcb_b), .PCSource(pcs_b), .PCWrite(pcw_b),
    .IorD(iord_b), .MemRead(mrd_b), .MemWrite(mwr_b), .IRWrite(irw_b), .RegDst(rdst_b),
    .MemtoReg(m2r_b), .RegWrite(rw_b), .Illegal(ill_b), .State(st_b)
  );

  assign obs_a = {st_a, alu_a, srca_a, srcb_a, pcs_a, pcw_a, iord_a, mrd_a, mwr_a, irw_a,
                  rdst_a, m2r_a, rw_a, ill_a};
  assign obs_b = {st_b, alu_b, srca_b, srcb_b, pcs_b, pcw_b, iord_b, mrd_b, mwr_b, irw_b,
                  rdst_b, m2r_b, rw_b, ill_b};

  // Reference: the whole per-cycle control word sequence of one instruction.
  task automatic build_model(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input bit bne_en);
    cyc_t       c;
    logic [3:0] rc;
    bit         rlegal;
    exp_q.delete();
    c = '0; c.st = 4'd0; c.mrd = 1; c.irw = 1; c.srcb = 2'd1; c.alu = 4'd2; c.pcw = 1;
    exp_q.push_back(c);
    c = '0; c.st = 4'd1; c.srcb = 2'd3; c.alu = 4'd2;
    exp_q.push_back(c);
    rlegal = 1;
    case (fn)
      6'h20:   rc = 4'd2;
      6'h22:   rc = 4'd6;
      6'h24:   rc = 4'd0;
      6'h25:   rc = 4'd1;
      6'h2A:   rc = 4'd7;
      6'h27:   rc = 4'd12;
      default: begin rc = 4'd2; rlegal = 0; end
    endcase
    if (op == 6'h23 || op == 6'h2B) begin
      c = '0; c.st = 4'd2; c.srca = 1; c.srcb = 2'd2; c.alu = 4'd2; exp_q.push_back(c);
      if (op == 6'h23) begin
        c = '0; c.st = 4'd3; c.mrd = 1; c.iord = 1; exp_q.push_back(c);
        c = '0; c.st = 4'd4; c.rw = 1; c.m2r = 1; exp_q.push_back(c);
      end else begin
        c = '0; c.st = 4'd5; c.mwr = 1; c.iord = 1; exp_q.push_back(c);
      end
    end else if (op == 6'h00) begin
      c = '0; c.st = 4'd6; c.srca = 1; c.alu = rc; exp_q.push_back(c);
      if (rlegal) begin
        c = '0; c.st = 4'd7; c.rw = 1; c.rdst = 1; exp_q.push_back(c);
      end else begin
        c = '0; c.st = 4'd12; c.ill = 1; exp_q.push_back(c);
      end
    end else if (op == 6'h04 || (op == 6'h05 && bne_en)) begin
      c = '0; c.st = 4'd8; c.srca = 1; c.alu = 4'd6; c.pcsrc = 2'd1;
      c.pcw = (op == 6'h04) ? z : !z;
      exp_q.push_back(c);
    end else if (op == 6'h02) begin
      c = '0; c.st = 4'd9; c.pcsrc = 2'd2; c.pcw = 1; exp_q.push_back(c);
    end else if (op == 6'h08 || op == 6'h0A) begin
      c = '0; c.st = 4'd10; c.srca = 1; c.srcb = 2'd2; c.alu = (op == 6'h0A) ? 4'd7 : 4'd2;
      exp_q.push_back(c);
      c = '0; c.st = 4'd11; c.rw = 1; exp_q.push_back(c);
    end else begin
      c = '0; c.st = 4'd12; c.ill = 1; exp_q.push_back(c);
    end
  endtask

  // Runs one instruction starting in FETCH (before its sample point); ncyc=0 runs to the end.
  task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input int ncyc);
    int n;
    build_model(op, fn, z, 1'b1);
    exp_a = exp_q;
    build_model(op, fn, z, 1'b0);
    exp_b = exp_q;
    n = (ncyc == 0) ? exp_a.size() : ncyc;
    for (int i = 0; i < n; i++) begin
      // Zero is noise everywhere except the branch cycle.
      Zero = (exp_a[i].st == 4'd8) ? z : 1'($urandom);
      @(negedge clock);
      vectors++;
      if (obs_a !== exp_a[i]) begin
        miscompares++;
        $display("FAIL %s cyc%0d bne_on: got %h want %h", name, i, obs_a, exp_a[i]);
      end
      vectors++;
      if (obs_b !== exp_b[i]) begin
        miscompares++;
        $display("FAIL %s cyc%0d bne_off: got %h want %h", name, i, obs_b, exp_b[i]);
      end
      if (i == 0) begin
        Op    = op;
        Funct = fn;
      end
    end
  endtask

  task automatic check_reset_outputs(input string name);
    cyc_t r;
    r = '0;
    r.alu = 4'd2;
    vectors++;
    if (obs_a !== r) begin
      miscompares++;
      $display("FAIL %s bne_on: got %h want %h", name, obs_a, r);
    end
    vectors++;
    if (obs_b !== r) begin
      miscompares++;
      $display("FAIL %s bne_off: got %h want %h", name, obs_b, r);
    end
  endtask

  task automatic test_reset;
    #2;
    check_reset_outputs("reset_hold");
    @(posedge clock);
    #1;
    check_reset_outputs("reset_hold_clk");
    reset = 1'b0;
  endtask

  task automatic test_rtype;
    run_instr("rtype_slt", 6'h00, 6'h2A, 1'b0, 0);
    run_instr("rtype_sub", 6'h00, 6'h22, 1'b1, 0);
    run_instr("rtype_nor", 6'h00, 6'h27, 1'b0, 0);
  endtask

  task automatic test_mem;
    run_instr("lw", 6'h23, 6'h00, 1'b0, 0);
    run_instr("sw", 6'h2B, 6'h11, 1'b1, 0);
  endtask

  task automatic test_branch;
    run_instr("beq_taken", 6'h04, 6'h00, 1'b1, 0);
    run_instr("beq_not", 6'h04, 6'h00, 1'b0, 0);
    run_instr("bne_taken", 6'h05, 6'h00, 1'b0, 0);
    run_instr("bne_not", 6'h05, 6'h00, 1'b1, 0);
  endtask

  task automatic test_imm_jump;
    run_instr("slti", 6'h0A, 6'h00, 1'b0, 0);
    run_instr("addi", 6'h08, 6'h3F, 1'b1, 0);
    run_instr("jump", 6'h02, 6'h00, 1'b0, 0);
  endtask

  task automatic test_illegal;
    run_instr("ill_op", 6'h3F, 6'h20, 1'b0, 0);
    run_instr("ill_funct", 6'h00, 6'h03, 1'b0, 0);
  endtask

  // Abort a store mid-MEMWR: outputs must drop with no clock edge.
  task automatic test_reset_midway;
    run_instr("sw_pre", 6'h2B, 6'h00, 1'b0, 3);
    @(posedge clock);
    #1;
    vectors++;
    if (mwr_a !== 1'b1 || st_a !== 4'd5) begin
      miscompares++;
      $display("FAIL memwr_before_reset: got st=%0d mw=%b want st=5 mw=1", st_a, mwr_a);
    end
    reset = 1'b1;
    #1;
    check_reset_outputs("reset_async");
    @(posedge clock);
    #1;
    check_reset_outputs("reset_async_clk");
    reset = 1'b0;
    run_instr("after_reset", 6'h00, 6'h24, 1'b0, 0);
  endtask

  task automatic test_random;
    logic [5:0] ops[10];
    logic [5:0] fns[8];
    logic [5:0] op, fn;
    ops = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0A, 6'h23, 6'h2B, 6'h00, 6'h00};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27, 6'h20, 6'h00};
    for (int k = 0; k < 60; k++) begin
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 9)];
      fn = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fns[$urandom_range(0, 7)];
      run_instr("random", op, fn, 1'($urandom), 0);
    end
  endtask

  task automatic test_back_to_back;
    run_instr("b2b_beq", 6'h04, 6'h00, 1'b1, 0);
    run_instr("b2b_lw", 6'h23, 6'h00, 1'b1, 0);
    run_instr("b2b_j", 6'h02, 6'h00, 1'b1, 0);
    run_instr("b2b_ill", 6'h11, 6'h00, 1'b0, 0);
  endtask

  initial begin
    test_reset;
    test_rtype;
    test_mem;
    test_branch;
    test_imm_jump;
    test_illegal;
    test_reset_midway;
    test_back_to_back;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Multicycle MIPS control unit: the producer side of the ALU control/operand/flag interface.
- Drives ALUctl and operand selects into the datapath ALU and consumes its Zero flag for branch resolution.
- Sequences fetch/decode/execute/memory/writeback through a Moore FSM; the PC write enable is Mealy on Zero.
- Sits between the instruction register and the datapath muxes, register file and memory strobes.

Parameters:
- ENABLE_BNE, 1, when 1 opcode 0x05 (bne) is decoded as a branch; when 0 it is treated as illegal.
- RESET_STATE, 0, state code loaded on reset (FETCH).

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- Op  in  6  IR[31:26], stable from the end of FETCH until the next FETCH
- Funct  in  6  IR[5:0]
- Zero  in  1  ALU zero flag, valid combinationally in the same cycle as ALUctl
- ALUctl  out  4  0=AND 1=OR 2=ADD 6=SUB 7=SLT 12=NOR
- ALUSrcA  out  1  0=PC, 1=register A
- ALUSrcB  out  2  0=B, 1=const 4, 2=signext imm, 3=signext imm<<2
- PCSource  out  2  0=ALU result, 1=ALUOut reg, 2=jump target
- PCWrite  out  1  PC load enable (includes the resolved branch)
- IorD  out  1  0=PC address, 1=ALUOut address
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register load
- RegDst  out  1  0=rt, 1=rd
- MemtoReg  out  1  0=ALUOut, 1=MDR
- RegWrite  out  1  register file write
- Illegal  out  1  one-cycle pulse on an undecodable Op/Funct
- State  out  4  current state, for debug

Behaviour:
- State register is 4 bits. On the reset edge it loads RESET_STATE asynchronously.
- While reset=1, all strobes (PCWrite, MemRead, MemWrite, IRWrite, RegWrite, Illegal) are forced to 0.
- All other outputs reset to 0; ALUctl resets to 2.
- Outputs are a decode of State. The only exception is PCWrite in BRANCH, which depends on Zero.
- Unlisted outputs are 0 in every state.
- States and transitions:
  - 0 FETCH: MemRead=1, IRWrite=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUctl=2, PCSource=0, PCWrite=1 -> DECODE.
  - 1 DECODE: ALUSrcA=0, ALUSrcB=3, ALUctl=2. Next state by Op:
    - 0x23 or 0x2B -> MEMADR
    - 0x00 -> EXEC_R
    - 0x04 -> BRANCH; 0x05 -> BRANCH when ENABLE_BNE=1
    - 0x02 -> JUMP
    - 0x08 or 0x0A -> IMM_EX
    - anything else -> ILLEGAL
  - 2 MEMADR: ALUSrcA=1, ALUSrcB=2, ALUctl=2 -> MEMRD if Op=0x23, else MEMWR.
  - 3 MEMRD: MemRead=1, IorD=1 -> MEMWB.
  - 4 MEMWB: RegWrite=1, MemtoReg=1, RegDst=0 -> FETCH.
  - 5 MEMWR: MemWrite=1, IorD=1 -> FETCH.
  - 6 EXEC_R: ALUSrcA=1, ALUSrcB=0. ALUctl by Funct: 0x20->2, 0x22->6, 0x24->0, 0x25->1, 0x2A->7, 0x27->12. Next: ALUWB, or ILLEGAL for any other Funct (ALUctl=2 in that case).
  - 7 ALUWB: RegWrite=1, RegDst=1, MemtoReg=0 -> FETCH.
  - 8 BRANCH: ALUSrcA=1, ALUSrcB=0, ALUctl=6, PCSource=1. PCWrite=Zero for Op=0x04 and PCWrite=~Zero for Op=0x05 -> FETCH.
  - 9 JUMP: PCSource=2, PCWrite=1 -> FETCH.
  - 10 IMM_EX: ALUSrcA=1, ALUSrcB=2, ALUctl=2 for 0x08 and 7 for 0x0A -> IMM_WB.
  - 11 IMM_WB: RegWrite=1, RegDst=0, MemtoReg=0 -> FETCH.
  - 12 ILLEGAL: Illegal=1 for exactly one cycle, no other strobes -> FETCH.
- State codes 13-15 are unreachable. If entered, the FSM goes -> FETCH with all strobes 0.
- Latencies in cycles, FETCH through the last state inclusive: lw=5, sw=4, R-type=4, addi/slti=4, beq/bne=3, j=3, illegal=3.
- Op and Funct are sampled only in DECODE, EXEC_R, MEMADR, BRANCH and IMM_EX. Changes in other states are ignored.
- Reset asserted mid-instruction aborts it immediately; no strobe fires after reset assertion. The first cycle after deassertion is FETCH.
- Zero toggling in any state other than BRANCH has no effect.

Test Plan:
- Reset: assert reset mid-MEMWR (State=5) -> MemWrite drops to 0 without waiting for a clock edge, State=0. Release reset -> the next cycle shows FETCH with PCWrite=1 and ALUctl=2.
- R-type: Op=0x00, Funct=0x2A -> State sequence 0,1,6,7,0. ALUctl=7 in EXEC_R. RegWrite=1 with RegDst=1 only in ALUWB.
- lw / sw: Op=0x23 -> states 0,1,2,3,4 with MemtoReg=1, RegWrite=1 in MEMWB. Op=0x2B -> states 0,1,2,5 with MemWrite=1 for exactly one cycle.
- Branch: beq with Zero=1 -> PCWrite=1, PCSource=1 in BRANCH. beq with Zero=0 -> PCWrite=0. bne with Zero=0 -> PCWrite=1. With ENABLE_BNE=0, Op=0x05 -> ILLEGAL.
- Immediate/jump: Op=0x0A -> ALUctl=7 in IMM_EX, RegDst=0 in IMM_WB. Op=0x02 -> PCSource=2, PCWrite=1, 3-cycle instruction.
- Illegal: Op=0x3F -> Illegal pulses for 1 cycle at State=12, then FETCH. Op=0x00 with Funct=0x03 -> ILLEGAL via EXEC_R, and RegWrite never asserts.
